// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron datapath and its spike event encoder.
//   LIF_W          : width of ISI values, spike counters and window lengths
//   SPK_FIFO_DEPTH : default depth of the spike event FIFO
//   isi_t          : unsigned ISI / counter value
//   sat_inc()      : increment that sticks at the all-ones value instead of wrapping
package lif_pkg;

  localparam int LIF_W          = 8;
  localparam int SPK_FIFO_DEPTH = 4;

  typedef logic [LIF_W-1:0] isi_t;

  function automatic isi_t sat_inc(input isi_t v);
    return (v == '1) ? v : v + isi_t'(1);
  endfunction

endpackage

// File: rtl/spike_fifo.sv
// Show-ahead synchronous FIFO for spike events.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset (discards contents)
//   push, push_data : write request and data; accepted if not full or popping
//   pop             : remove head entry (ignored when empty)
//   head_data       : head entry, forced to 0 while empty
//   full, empty     : occupancy flags
//   level           : current occupancy, 0..DEPTH
//   drop            : push rejected this cycle (full and not popping)
module spike_fifo
  import lif_pkg::*;
#(
  parameter int W     = LIF_W,
  parameter int DEPTH = SPK_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count_q == LW'(DEPTH));
  assign empty = (count_q == '0);
  assign level = count_q;

  // A pop frees the slot in the same cycle, so a push at full still lands.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  // Gating keeps the output at 0 after reset without clearing the storage.
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/spike_event_encoder.sv
// Converts the neuron's spike level into inter-spike-interval events (buffered
// in a small FIFO with valid/ready output) and a per-window spike-rate count.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   en                     : enables ISI and window counting
//   spike_in               : spike level from neuron; each rising edge is one spike
//   win_len                : window length in enabled cycles (0 means 2^W)
//   evt_data/valid/ready   : ISI event stream, show-ahead
//   rate_count, rate_valid : spike count of last window, one-cycle update pulse
//   overflow               : sticky, an event was dropped on a full FIFO
//   fifo_level             : FIFO occupancy
module spike_event_encoder
  import lif_pkg::*;
#(
  parameter int W     = LIF_W,
  parameter int DEPTH = SPK_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   spike_in,
  input  logic [W-1:0]           win_len,
  output logic [W-1:0]           evt_data,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [W-1:0]           rate_count,
  output logic                   rate_valid,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_level
);

  logic         spike_q,      spike_d;
  logic [W-1:0] isi_cnt_q,    isi_cnt_d;
  logic [W-1:0] win_cnt_q,    win_cnt_d;
  logic [W-1:0] spk_cnt_q,    spk_cnt_d;
  logic [W-1:0] len_q,        len_d;
  logic [W-1:0] rate_count_q, rate_count_d;
  logic         rate_valid_q, rate_valid_d;
  logic         overflow_q,   overflow_d;

  logic         spike_edge;
  logic [W-1:0] push_val;
  logic [W-1:0] len_m1;
  logic         win_last;
  logic         fifo_pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_drop;

  // Gating with en means an edge seen while disabled is simply lost; spike_q
  // keeps tracking, so a level still high at re-enable is not a new edge.
  assign spike_edge = spike_in & ~spike_q & en;
  assign push_val   = sat_inc(isi_cnt_q);

  // len_q = 0 wraps to all-ones here, giving a 2^W-cycle window for free.
  assign len_m1   = len_q - 1'b1;
  assign win_last = (win_cnt_q == len_m1);

  assign fifo_pop = evt_valid & evt_ready;

  always_comb begin
    spike_d      = spike_in;
    isi_cnt_d    = isi_cnt_q;
    win_cnt_d    = win_cnt_q;
    spk_cnt_d    = spk_cnt_q;
    len_d        = len_q;
    rate_count_d = rate_count_q;
    rate_valid_d = 1'b0;
    overflow_d   = overflow_q | fifo_drop;

    if (en) begin
      isi_cnt_d = spike_edge ? '0 : sat_inc(isi_cnt_q);

      if (win_last) begin
        // An edge on the closing cycle still belongs to this window.
        rate_count_d = spike_edge ? sat_inc(spk_cnt_q) : spk_cnt_q;
        rate_valid_d = 1'b1;
        spk_cnt_d    = '0;
        win_cnt_d    = '0;
        len_d        = win_len;
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
        if (spike_edge) spk_cnt_d = sat_inc(spk_cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spike_q      <= 1'b0;
      isi_cnt_q    <= '0;
      win_cnt_q    <= '0;
      spk_cnt_q    <= '0;
      len_q        <= win_len;
      rate_count_q <= '0;
      rate_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      spike_q      <= spike_d;
      isi_cnt_q    <= isi_cnt_d;
      win_cnt_q    <= win_cnt_d;
      spk_cnt_q    <= spk_cnt_d;
      len_q        <= len_d;
      rate_count_q <= rate_count_d;
      rate_valid_q <= rate_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  spike_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (spike_edge),
    .push_data (push_val),
    .pop       (fifo_pop),
    .head_data (evt_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .drop      (fifo_drop)
  );

  assign evt_valid  = ~fifo_empty;
  assign rate_count = rate_count_q;
  assign rate_valid = rate_valid_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_spike_event_encoder.sv
module tb_spike_event_encoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       spike_in;
  logic [7:0] win_len;
  logic [7:0] evt_data;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] rate_count;
  logic       rate_valid;
  logic       overflow;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;

  spike_event_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .spike_in   (spike_in),
    .win_len    (win_len),
    .evt_data   (evt_data),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .rate_count (rate_count),
    .rate_valid (rate_valid),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] wl, input logic e);
    rst_n     = 1'b0;
    win_len   = wl;
    spike_in  = 1'b0;
    en        = e;
    evt_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(8'd5, 1'b1);
    for (int c = 0; c < 8; c++) begin
      spike_in = (c == 2) || (c == 5);
      tick();
    end
    checks++;
    if (fifo_level !== 3'd2) begin
      errors++; $display("FAIL rst_prefill got %0d want 2", fifo_level);
    end
    // Reset with buffered events and spike_in held high.
    rst_n = 1'b0; spike_in = 1'b1; en = 1'b1; evt_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({evt_valid, evt_data, rate_count, rate_valid, overflow, fifo_level} !== '0) begin
      errors++;
      $display("FAIL rst_outputs got v=%0b d=%0d rc=%0d rv=%0b ov=%0b lvl=%0d want all 0",
               evt_valid, evt_data, rate_count, rate_valid, overflow, fifo_level);
    end
    $display("reset: outputs after 3 reset cycles lvl=%0d", fifo_level);
    // Release disabled with the spike still high; enabling later must not see an edge.
    rst_n = 1'b1; en = 1'b0;
    tick(); tick();
    en = 1'b1;
    repeat (5) tick();
    checks++;
    if (fifo_level !== 3'd0 || evt_valid !== 1'b0) begin
      errors++; $display("FAIL rst_release_no_event got lvl=%0d v=%0b want 0 0", fifo_level, evt_valid);
    end
    spike_in = 1'b0;
  endtask

  task automatic test_isi();
    logic [7:0] exp_d;
    logic       exp_v;
    do_reset(8'd100, 1'b1);
    evt_ready = 1'b1;
    for (int c = 0; c < 23; c++) begin
      spike_in = (c == 10) || (c == 15) || (c == 20);
      tick();
      exp_v = (c == 10) || (c == 15) || (c == 20);
      exp_d = (c == 10) ? 8'd11 : 8'd5;
      checks++;
      if (evt_valid !== exp_v) begin
        errors++; $display("FAIL isi_valid c=%0d got %0b want %0b", c, evt_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (evt_data !== exp_d) begin
          errors++; $display("FAIL isi_data c=%0d got %0d want %0d", c, evt_data, exp_d);
        end
        $display("isi: c=%0d event %0d", c, evt_data);
      end
    end
  endtask

  task automatic test_saturation();
    int n_evt;
    do_reset(8'd100, 1'b1);
    evt_ready = 1'b1;
    n_evt = 0;
    for (int c = 0; c < 835; c++) begin
      spike_in = (c == 1) || (c == 301) || (c == 556) || (c == 810) || (c >= 820 && c <= 823);
      tick();
      if (c == 1 || c == 301 || c == 556 || c == 810) begin
        logic [7:0] exp_d;
        exp_d = (c == 1) ? 8'd2 : (c == 810) ? 8'd254 : 8'd255;
        checks++;
        if (evt_valid !== 1'b1 || evt_data !== exp_d) begin
          errors++; $display("FAIL sat_isi c=%0d got v=%0b d=%0d want v=1 d=%0d", c, evt_valid, evt_data, exp_d);
        end
        $display("sat: c=%0d event %0d", c, evt_data);
      end
      if (c >= 820 && evt_valid === 1'b1) begin
        n_evt++;
        checks++;
        if (evt_data !== 8'd10) begin
          errors++; $display("FAIL multi_cycle_data c=%0d got %0d want 10", c, evt_data);
        end
      end
    end
    checks++;
    if (n_evt != 1) begin
      errors++; $display("FAIL multi_cycle_count got %0d want 1", n_evt);
    end
    $display("multi-cycle: %0d event(s) from 4-cycle high", n_evt);
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_q [4];
    exp_q = '{8'd5, 8'd3, 8'd3, 8'd3};
    do_reset(8'd100, 1'b1);
    evt_ready = 1'b0;
    for (int c = 0; c < 18; c++) begin
      spike_in = (c == 4) || (c == 7) || (c == 10) || (c == 13) || (c == 16);
      tick();
      if (c == 13) begin
        checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
          errors++; $display("FAIL bp_full_no_ovf got lvl=%0d ov=%0b want 4 0", fifo_level, overflow);
        end
      end
    end
    checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
      errors++; $display("FAIL bp_overflow got lvl=%0d ov=%0b want 4 1", fifo_level, overflow);
    end
    checks++;
    if (evt_data !== 8'd5) begin
      errors++; $display("FAIL bp_head_stable got %0d want 5", evt_data);
    end
    evt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (evt_valid !== 1'b1 || evt_data !== exp_q[k]) begin
        errors++; $display("FAIL bp_drain k=%0d got v=%0b d=%0d want v=1 d=%0d", k, evt_valid, evt_data, exp_q[k]);
      end
      $display("bp: pop %0d value %0d", k, evt_data);
      tick();
    end
    checks++;
    if (evt_valid !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b1) begin
      errors++; $display("FAIL bp_after_drain got v=%0b lvl=%0d ov=%0b want 0 0 1", evt_valid, fifo_level, overflow);
    end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp_q [4];
    exp_q = '{8'd3, 8'd3, 8'd3, 8'd5};
    do_reset(8'd100, 1'b1);
    for (int c = 0; c < 19; c++) begin
      spike_in  = (c == 4) || (c == 7) || (c == 10) || (c == 13) || (c == 18);
      evt_ready = (c == 18);
      tick();
    end
    evt_ready = 1'b0;
    spike_in  = 1'b0;
    checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      errors++; $display("FAIL pp_full got lvl=%0d ov=%0b want 4 0", fifo_level, overflow);
    end
    evt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (evt_valid !== 1'b1 || evt_data !== exp_q[k]) begin
        errors++; $display("FAIL pp_drain k=%0d got v=%0b d=%0d want v=1 d=%0d", k, evt_valid, evt_data, exp_q[k]);
      end
      $display("pp: pop %0d value %0d", k, evt_data);
      tick();
    end
  endtask

  task automatic test_rate_window();
    logic exp_v;
    logic [7:0] exp_c;
    do_reset(8'd10, 1'b1);
    evt_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      spike_in = (c == 0) || (c == 4) || (c == 9);
      if (c == 12) win_len = 8'd3;
      tick();
      exp_v = (c == 9) || (c == 19) || (c == 22);
      exp_c = (c == 9) ? 8'd3 : 8'd0;
      checks++;
      if (rate_valid !== exp_v) begin
        errors++; $display("FAIL rate_valid c=%0d got %0b want %0b", c, rate_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (rate_count !== exp_c) begin
          errors++; $display("FAIL rate_count c=%0d got %0d want %0d", c, rate_count, exp_c);
        end
        $display("rate: c=%0d count %0d", c, rate_count);
      end
    end
  endtask

  task automatic test_win_zero();
    int first, second;
    first = -1; second = -1;
    do_reset(8'd0, 1'b1);
    evt_ready = 1'b1;
    for (int c = 0; c < 520; c++) begin
      tick();
      if (rate_valid === 1'b1) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    checks++;
    if (first != 255) begin
      errors++; $display("FAIL win0_first got %0d want 255", first);
    end
    checks++;
    if (second - first != 256) begin
      errors++; $display("FAIL win0_period got %0d want 256", second - first);
    end
    $display("win0: pulses at %0d and %0d", first, second);
  endtask

  task automatic test_enable_gating();
    do_reset(8'd50, 1'b1);
    for (int c = 0; c < 71; c++) begin
      en        = !(c >= 10 && c < 30);
      evt_ready = (c >= 10);
      spike_in  = (c == 4) || (c == 12) || (c == 20) || (c >= 25 && c <= 31) || (c == 33);
      tick();
      if (c == 9) begin
        checks++;
        if (fifo_level !== 3'd1 || evt_data !== 8'd5) begin
          errors++; $display("FAIL gate_pre got lvl=%0d d=%0d want 1 5", fifo_level, evt_data);
        end
      end
      if (c == 10 || c == 29 || c == 31) begin
        checks++;
        if (fifo_level !== 3'd0 || evt_valid !== 1'b0) begin
          errors++; $display("FAIL gate_no_event c=%0d got lvl=%0d v=%0b want 0 0", c, fifo_level, evt_valid);
        end
      end
      if (c == 33) begin
        checks++;
        if (evt_valid !== 1'b1 || evt_data !== 8'd9) begin
          errors++; $display("FAIL gate_isi_frozen got v=%0b d=%0d want 1 9", evt_valid, evt_data);
        end
        $display("gate: event after re-enable %0d", evt_data);
      end
      if (c >= 10) begin
        checks++;
        if (rate_valid !== (c == 69)) begin
          errors++; $display("FAIL gate_rate_valid c=%0d got %0b want %0b", c, rate_valid, (c == 69));
        end
      end
      if (c == 69) begin
        checks++;
        if (rate_count !== 8'd2) begin
          errors++; $display("FAIL gate_rate_count got %0d want 2", rate_count);
        end
        $display("gate: rate_count %0d at c=%0d", rate_count, c);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; spike_in = 1'b0; win_len = 8'd0; evt_ready = 1'b0;
    test_reset();
    test_isi();
    test_saturation();
    test_backpressure();
    test_push_pop_full();
    test_rate_window();
    test_win_zero();
    test_enable_gating();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_event_encoder.md
Name: spike_event_encoder

Overview:
- Downstream stage of the leaky integrate-and-fire neuron; consumes its 1-bit spike output.
- Converts spikes into inter-spike-interval (ISI) events and buffers them in a small FIFO with a valid/ready output.
- Produces a per-window spike-rate count alongside the events.
- Sits between the neuron and the chip-level output pins or a readout stage.

Parameters:
- W, 8, width of ISI values, counters and window length.
- DEPTH, 4, FIFO depth in entries; must be a power of two, ≥2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  enables ISI and window counting.
- spike_in  input  1  spike from neuron (level; multi-cycle highs count once).
- win_len  input  W  rate-window length in enabled cycles; 0 means 2^W.
- evt_data  output  W  ISI value at FIFO head.
- evt_valid  output  1  FIFO non-empty.
- evt_ready  input  1  consumer accepts head this cycle.
- rate_count  output  W  spike count of last completed window.
- rate_valid  output  1  one-cycle pulse when rate_count updates.
- overflow  output  1  sticky; an event was dropped on a full FIFO.
- fifo_level  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n=0 at clock edge):
  - All outputs go to 0.
  - spike_q, isi_cnt, win_cnt, spk_cnt and FIFO pointers clear.
  - Reset mid-transfer discards all buffered events.
- Edge detect:
  - spike_q <= spike_in every cycle, regardless of en.
  - edge = spike_in & ~spike_q & en.
  - A rising edge arriving while en=0 is lost; re-enabling never creates a phantom edge.
- ISI counter (isi_cnt, W bits):
  - When en=1 and no edge: isi_cnt increments, saturating at 2^W-1.
  - On edge: push value = min(isi_cnt+1, 2^W-1), then isi_cnt <= 0.
  - Two edges N cycles apart push N; N ≥ 2^W pushes 2^W-1.
  - The first edge after reset uses the same rule.
- FIFO:
  - Show-ahead; evt_data is the head entry.
  - Push lands at the edge clock; evt_valid rises the next cycle (latency 1). There is no combinational bypass.
  - Pop occurs when evt_valid & evt_ready.
  - Push while full and not popping: entry dropped, overflow <= 1. overflow clears only on reset.
  - Push and pop in the same cycle while full: both happen, level unchanged, no overflow.
  - Push and pop in the same cycle otherwise: level unchanged.
  - Pointers wrap modulo DEPTH.
  - evt_data is held stable while evt_valid & ~evt_ready.
  - The output handshake operates independently of en.
- Rate window:
  - len_q captures win_len at reset release and at every window start. Mid-window changes to win_len are ignored.
  - win_cnt counts enabled cycles 0 … len_q-1 (len_q=0 means 2^W cycles).
  - spk_cnt increments on edge, saturating at 2^W-1.
  - On the last enabled cycle of a window:
    - rate_count <= spk_cnt + edge (saturating).
    - rate_valid <= 1 for one cycle.
    - spk_cnt <= 0, win_cnt <= 0.
  - While en=0 the window freezes and rate_valid stays 0.
- Arithmetic is unsigned throughout; no value ever wraps, only saturates.

Decomposition:
- Shared package lif_pkg:
  - LIF_W = 8.
  - SPK_FIFO_DEPTH = 4.
  - Typedef isi_t (logic [LIF_W-1:0]).
  - Function sat_inc(isi_t) returning the saturated increment.
- One sub-module: spike_fifo.
  - Parameterised synchronous FIFO with push/pop, full/empty and level outputs.
  - Same clk/rst_n convention.
  - Edge detect, ISI counter and window logic stay in the top module.

Test Plan:
- Reset behaviour: hold rst_n=0 for 3 cycles with spike_in=1 → all outputs 0. Release with spike_in held high → no event.
- ISI values: en=1, evt_ready=1, win_len=100.
  - Single-cycle spikes at cycles 10, 15 and 20 after reset release.
  - Pushed events are 11, 5 and 5.
  - Each event's evt_valid is high exactly one cycle after its spike edge.
- Saturation and multi-cycle spikes:
  - A spike_in gap of 300 cycles → event 255.
  - spike_in held high for 4 cycles → exactly one event.
- Backpressure and overflow: evt_ready=0, 5 spikes 3 cycles apart, DEPTH=4.
  - fifo_level=4 and overflow=1 after the 5th spike.
  - On releasing ready, events pop as 3, 3, 3, 3 (first is cycle-dependent) and the 5th is absent.
  - Separately, a push coinciding with a pop at full → no overflow.
- Rate window: win_len=10, spikes at window cycles 0, 4 and 9 (last).
  - rate_count=3 with a rate_valid pulse after cycle 9.
  - win_len=0 → rate_valid period of 256 enabled cycles.
- Enable gating: en=0 for 20 cycles mid-window while spikes occur.
  - No events are pushed.
  - isi_cnt and win_cnt are frozen.
  - The FIFO still drains with evt_ready=1.
